// File: rtl/coin_pkg.sv
// coin_pkg -- definitions shared by the coin acceptor and the vending FSM.
//   coin_state_t : 2-bit acceptor state encoding
//   COIN_*       : coin values presented on the acceptor's coin output
//   coin_value() : maps the latched coin kind to its coin value
package coin_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_QUAL    = 2'd1,
        ST_HOLD    = 2'd2,
        ST_RELEASE = 2'd3
    } coin_state_t;

    localparam logic [4:0] COIN_NONE = 5'd0;
    localparam logic [4:0] COIN_5    = 5'd5;
    localparam logic [4:0] COIN_10   = 5'd10;

    // is_ten selects the 10-unit coin, otherwise the 5-unit coin
    function automatic logic [4:0] coin_value(input logic is_ten);
        logic [4:0] val;
        if (is_ten) begin
            val = COIN_10;
        end else begin
            val = COIN_5;
        end
        return val;
    endfunction

endpackage

// File: rtl/sync2.sv
// sync2 -- two-flop synchronizer for one asynchronous, active-high input.
//   clk : sampling clock
//   rst : synchronous active-low reset, clears both flops
//   d   : asynchronous input
//   q   : input re-timed to clk, two cycles of latency
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    // next values of the two-stage shift
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // synchronizer flops
    always_ff @(posedge clk) begin
        if (!rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/coin_acceptor.sv
// coin_acceptor -- debounces the 5- and 10-unit coin sensors, holds a
// qualified coin until the vending FSM is ready, and diverts ambiguous or
// stale coins to the return chute.
//   Parameters: DEB_CYCLES (2..15) stable cycles to qualify a coin,
//               HOLD_MAX (1..255) cycles a qualified coin may wait for ready.
//   clk    : clock, all state changes on the rising edge
//   rst    : synchronous active-low reset
//   sens5  : raw 5-unit sensor (asynchronous, bouncy)
//   sens10 : raw 10-unit sensor (asynchronous, bouncy)
//   ready  : downstream can take a coin this cycle
//   coin   : registered coin value, nonzero for exactly one accept cycle
//   reject : registered one-cycle return-chute pulse
//   busy   : registered, high whenever the state is not IDLE
module coin_acceptor
    import coin_pkg::*;
#(
    parameter int DEB_CYCLES = 4,
    parameter int HOLD_MAX   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sens5,
    input  logic       sens10,
    input  logic       ready,
    output logic [4:0] coin,
    output logic       reject,
    output logic       busy
);

    localparam logic [7:0] DEB_LAST  = 8'(DEB_CYCLES - 1);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    logic        s5;
    logic        s10;
    logic        latched_s;
    logic        other_s;

    coin_state_t state_q;
    coin_state_t state_d;
    logic [7:0]  cnt_q;
    logic [7:0]  cnt_d;
    logic        kind10_q;
    logic        kind10_d;
    logic [4:0]  coin_q;
    logic [4:0]  coin_d;
    logic        reject_q;
    logic        reject_d;
    logic        busy_q;
    logic        busy_d;

    sync2 u_sync5 (
        .clk (clk),
        .rst (rst),
        .d   (sens5),
        .q   (s5)
    );

    sync2 u_sync10 (
        .clk (clk),
        .rst (rst),
        .d   (sens10),
        .q   (s10)
    );

    // the sensor chosen on entry to QUAL, and the opposite one
    assign latched_s = kind10_q ? s10 : s5;
    assign other_s   = kind10_q ? s5  : s10;

    // next-state, shared counter and output decode
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        kind10_d = kind10_q;
        coin_d   = COIN_NONE;
        reject_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (s5 && s10) begin
                    reject_d = 1'b1;
                    state_d  = ST_RELEASE;
                end else if (s5 || s10) begin
                    state_d  = ST_QUAL;
                    kind10_d = s10;
                    cnt_d    = 8'd0;
                end else begin
                    state_d  = ST_IDLE;
                end
            end

            ST_QUAL: begin
                if (latched_s && other_s) begin
                    // two coins at once cannot be told apart: divert
                    reject_d = 1'b1;
                    state_d  = ST_RELEASE;
                    cnt_d    = 8'd0;
                end else if (!latched_s) begin
                    // sensor dropped before qualifying: treat as a glitch
                    state_d  = ST_IDLE;
                    cnt_d    = 8'd0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d  = ST_HOLD;
                    cnt_d    = 8'd0;
                end else begin
                    cnt_d    = cnt_q + 8'd1;
                end
            end

            ST_HOLD: begin
                // sensors are deliberately not looked at while holding
                if (ready) begin
                    coin_d   = coin_value(kind10_q);
                    state_d  = ST_RELEASE;
                    cnt_d    = 8'd0;
                end else if (cnt_q == HOLD_LAST) begin
                    reject_d = 1'b1;
                    state_d  = ST_RELEASE;
                    cnt_d    = 8'd0;
                end else begin
                    cnt_d    = cnt_q + 8'd1;
                end
            end

            ST_RELEASE: begin
                // wait for the coin to clear both sensors before re-arming
                if (!s5 && !s10) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RELEASE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // state, counter and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 8'd0;
            kind10_q <= 1'b0;
            coin_q   <= COIN_NONE;
            reject_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            kind10_q <= kind10_d;
            coin_q   <= coin_d;
            reject_q <= reject_d;
            busy_q   <= busy_d;
        end
    end

    assign coin   = coin_q;
    assign reject = reject_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor -- self-checking bench for coin_acceptor.
// Directed scenarios for the main behaviours plus randomized sensor/ready
// traffic, all compared cycle by cycle against a timestamp-based reference
// model of the acceptor's rules.
module tb_coin_acceptor;

    localparam int DEB  = 4;
    localparam int HOLD = 16;
    localparam int MAXE = 20000;

    // reference model activities
    localparam int AWAIT_COIN  = 0;
    localparam int DEBOUNCING  = 1;
    localparam int OFFERING    = 2;
    localparam int AWAIT_CLEAR = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sens5 = 1'b0;
    logic       sens10 = 1'b0;
    logic       ready = 1'b0;
    logic [4:0] coin;
    logic       reject;
    logic       busy;

    coin_acceptor #(
        .DEB_CYCLES (DEB),
        .HOLD_MAX   (HOLD)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .sens5  (sens5),
        .sens10 (sens10),
        .ready  (ready),
        .coin   (coin),
        .reject (reject),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // model state: raw input history per edge, timestamps instead of counters
    int e         = 0;
    int rst_edge  = 0;
    bit raw5  [MAXE];
    bit raw10 [MAXE];
    int act       = AWAIT_COIN;
    int val       = 0;
    int t_mark    = 0;
    int m_coin    = 0;
    int m_rej     = 0;
    int m_busy    = 0;

    // scenario statistics from observed outputs
    int rel       = 0;
    int n_coin    = 0;
    int n_rej     = 0;
    int coin_edge = -1;
    int rej_edge  = -1;
    int coin_seq[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // advance the reference model by one rising edge using the current inputs
    function automatic void model_step();
        bit v5;
        bit v10;
        bit mine;
        bit other;
        e++;
        raw5[e]  = sens5;
        raw10[e] = sens10;
        m_coin = 0;
        m_rej  = 0;
        if (!rst) begin
            rst_edge = e;
            act      = AWAIT_COIN;
        end else begin
            // the acceptor sees a sensor two edges after it is sampled,
            // and nothing sampled at or before a reset edge
            v5  = (e - 2 > rst_edge) ? raw5[e - 2]  : 1'b0;
            v10 = (e - 2 > rst_edge) ? raw10[e - 2] : 1'b0;
            case (act)
                AWAIT_COIN: begin
                    if (v5 && v10) begin
                        m_rej = 1;
                        act   = AWAIT_CLEAR;
                    end else if (v5 || v10) begin
                        val    = v5 ? 5 : 10;
                        t_mark = e;
                        act    = DEBOUNCING;
                    end
                end
                DEBOUNCING: begin
                    mine  = (val == 5) ? v5 : v10;
                    other = (val == 5) ? v10 : v5;
                    if (mine && other) begin
                        m_rej = 1;
                        act   = AWAIT_CLEAR;
                    end else if (!mine) begin
                        act = AWAIT_COIN;
                    end else if (e - t_mark == DEB) begin
                        t_mark = e;
                        act    = OFFERING;
                    end
                end
                OFFERING: begin
                    if (ready) begin
                        m_coin = val;
                        act    = AWAIT_CLEAR;
                    end else if (e - t_mark == HOLD) begin
                        m_rej = 1;
                        act   = AWAIT_CLEAR;
                    end
                end
                default: begin
                    if (!v5 && !v10) act = AWAIT_COIN;
                end
            endcase
        end
        m_busy = (act != AWAIT_COIN) ? 1 : 0;
    endfunction

    task automatic start_scn();
        rel       = 0;
        n_coin    = 0;
        n_rej     = 0;
        coin_edge = -1;
        rej_edge  = -1;
        coin_seq.delete();
    endtask

    // one clock: model steps on the edge, outputs compared on the falling edge
    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        rel++;
        check_eq("coin", 32'(coin), 32'(m_coin));
        check_eq("reject", 32'(reject), 32'(m_rej));
        check_eq("busy", 32'(busy), 32'(m_busy));
        check_eq("coin_rej_exclusive", 32'((coin != 5'd0) && reject), 32'd0);
        if (coin != 5'd0) begin
            n_coin++;
            coin_seq.push_back(int'(coin));
            if (coin_edge < 0) coin_edge = rel;
        end
        if (reject) begin
            n_rej++;
            if (rej_edge < 0) rej_edge = rel;
        end
    endtask

    initial begin
        int busy_fall;
        int kind;
        int dur;
        int gap;
        int rmode;

        // reset state
        rst = 1'b0;
        repeat (3) cyc();
        check_eq("rst_coin", 32'(coin), 32'd0);
        check_eq("rst_reject", 32'(reject), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        repeat (2) cyc();

        // clean 5-unit coin with ready high
        start_scn();
        ready = 1'b1;
        sens5 = 1'b1;
        repeat (20) cyc();
        sens5 = 1'b0;
        busy_fall = -1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (!busy && busy_fall < 0) busy_fall = rel;
        end
        check_eq("acc5_edge", 32'(coin_edge), 32'(DEB + 4));
        check_eq("acc5_count", 32'(n_coin), 32'd1);
        if (coin_seq.size() > 0) check_eq("acc5_value", 32'(coin_seq[0]), 32'd5);
        check_eq("acc5_reject", 32'(n_rej), 32'd0);
        check_eq("acc5_busy_fall", 32'(busy_fall), 32'd23);

        // 2-cycle glitch on the 10-unit sensor
        start_scn();
        sens10 = 1'b1;
        repeat (2) cyc();
        sens10 = 1'b0;
        repeat (8) cyc();
        check_eq("glitch_coin", 32'(n_coin), 32'd0);
        check_eq("glitch_reject", 32'(n_rej), 32'd0);
        check_eq("glitch_idle", 32'(busy), 32'd0);

        // both sensors together
        start_scn();
        sens5  = 1'b1;
        sens10 = 1'b1;
        repeat (6) cyc();
        sens5  = 1'b0;
        sens10 = 1'b0;
        repeat (5) cyc();
        check_eq("both_reject_cycles", 32'(n_rej), 32'd1);
        check_eq("both_reject_edge", 32'(rej_edge), 32'd3);
        check_eq("both_coin", 32'(n_coin), 32'd0);

        // hold timeout with ready low
        start_scn();
        ready  = 1'b0;
        sens10 = 1'b1;
        repeat (30) cyc();
        sens10 = 1'b0;
        repeat (5) cyc();
        check_eq("timeout_reject", 32'(n_rej), 32'd1);
        check_eq("timeout_edge", 32'(rej_edge), 32'(DEB + 3 + HOLD));
        check_eq("timeout_coin", 32'(n_coin), 32'd0);

        // ready rises in the fifth hold cycle
        start_scn();
        sens10 = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            if (i == DEB + 3 + 5) ready = 1'b1;
            cyc();
        end
        sens10 = 1'b0;
        repeat (5) cyc();
        check_eq("late_ready_edge", 32'(coin_edge), 32'(DEB + 8));
        check_eq("late_ready_count", 32'(n_coin), 32'd1);
        if (coin_seq.size() > 0) check_eq("late_ready_value", 32'(coin_seq[0]), 32'd10);
        check_eq("late_ready_reject", 32'(n_rej), 32'd0);

        // reset while holding discards the coin
        start_scn();
        ready  = 1'b0;
        sens10 = 1'b1;
        repeat (DEB + 3 + 3) cyc();
        check_eq("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        cyc();
        check_eq("midrst_coin", 32'(coin), 32'd0);
        check_eq("midrst_reject", 32'(reject), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        rst    = 1'b1;
        sens10 = 1'b0;
        start_scn();
        repeat (30) cyc();
        check_eq("post_rst_coin", 32'(n_coin), 32'd0);
        check_eq("post_rst_reject", 32'(n_rej), 32'd0);

        // sensor already high across reset release counts as a new insertion
        sens10 = 1'b1;
        ready  = 1'b1;
        rst    = 1'b0;
        cyc();
        rst = 1'b1;
        start_scn();
        repeat (15) cyc();
        sens10 = 1'b0;
        repeat (5) cyc();
        check_eq("held_rst_count", 32'(n_coin), 32'd1);
        check_eq("held_rst_edge", 32'(coin_edge), 32'(DEB + 4));

        // two insertions back to back
        start_scn();
        ready = 1'b1;
        sens5 = 1'b1;
        repeat (10) cyc();
        sens5 = 1'b0;
        repeat (4) cyc();
        sens10 = 1'b1;
        repeat (10) cyc();
        sens10 = 1'b0;
        repeat (5) cyc();
        check_eq("pair_count", 32'(n_coin), 32'd2);
        if (coin_seq.size() > 1) begin
            check_eq("pair_first", 32'(coin_seq[0]), 32'd5);
            check_eq("pair_second", 32'(coin_seq[1]), 32'd10);
        end
        check_eq("pair_reject", 32'(n_rej), 32'd0);

        // randomized traffic against the reference model
        for (int ep = 0; ep < 150; ep++) begin
            kind  = int'($urandom_range(0, 3));
            dur   = int'($urandom_range(1, 30));
            gap   = int'($urandom_range(0, 6));
            rmode = int'($urandom_range(0, 2));
            for (int i = 0; i < dur; i++) begin
                case (kind)
                    0: begin sens5 = 1'b1; sens10 = 1'b0; end
                    1: begin sens5 = 1'b0; sens10 = 1'b1; end
                    2: begin sens5 = 1'b1; sens10 = 1'b1; end
                    default: begin
                        sens5  = 1'($urandom_range(0, 1));
                        sens10 = 1'($urandom_range(0, 1));
                    end
                endcase
                if (rmode == 0) ready = 1'b1;
                else if (rmode == 1) ready = 1'b0;
                else ready = 1'($urandom_range(0, 1));
                rst = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
                cyc();
            end
            sens5  = 1'b0;
            sens10 = 1'b0;
            rst    = 1'b1;
            for (int i = 0; i < gap; i++) begin
                ready = 1'($urandom_range(0, 1));
                cyc();
            end
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
